// File: rtl/mcycle_ctrl.sv
// Multi-cycle CPU control unit: instruction sequencing FSM with memory handshake,
// per-access wait timeout, retire pulse/counter and sticky halt status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | instruction read; IR and PC+4 written on memory completion
// DECODE   | branch target precomputed into aluout; dispatch on opcode
// EXEC_R   | register-register ALU operation
// ALU_WB   | write R-type result to rd
// EXEC_I   | register-immediate ALU operation
// IMM_WB   | write immediate result to rt
// MEM_ADDR | effective address rs + signimm
// MEM_RD   | data read, waits for memory
// MEM_WB   | write loaded data to rt
// MEM_WR   | data write, waits for memory, retires on completion
// BRANCH   | compare rs/rt, conditional PC load from aluout
// JUMP     | PC <- jump target
// JAL      | r31 <- PC, PC <- jump target
// JR       | PC <- rs
// HALT     | stopped on illegal opcode or bus error; left only by reset
module mcycle_ctrl #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int TIMEOUT       = 15,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             iord,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             reg_we,
   output logic             reg_src,
   output logic             alusrc_a,
   output logic             branch,
   output logic             beq_sel,
   output logic [2:0]       aluop,
   output logic [1:0]       reg_dest,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       alusrc_b,
   output logic [1:0]       pc_src,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_EXEC_I, S_IMM_WB, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_JR  = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_SLT = 6'h2A;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             mem_done;
   logic             timed_out;

   always_comb begin
      mem_done   = (MEM_HANDSHAKE == 0) || mem_ready;
      // Timeout fires on the TIMEOUT-th consecutive not-ready cycle of one access
      timed_out  = (MEM_HANDSHAKE != 0) && !mem_ready && (wait_q == WAIT_LAST);

      state_d    = state_q;
      wait_d     = '0;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;

      pc_we      = 1'b0;
      iord       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      reg_we     = 1'b0;
      reg_src    = 1'b0;
      alusrc_a   = 1'b0;
      branch     = 1'b0;
      beq_sel    = 1'b0;
      aluop      = ALU_ADD;
      reg_dest   = 2'd0;
      mem_to_reg = 2'd0;
      alusrc_b   = 2'd0;
      pc_src     = 2'd0;
      retire     = 1'b0;
      halted     = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            alusrc_b = 2'd1;
            if (mem_done) begin
               ir_write = 1'b1;
               pc_we    = 1'b1;
               state_d  = S_DECODE;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            alusrc_b = 2'd3;
            if (opcode == OP_RTYPE && (funct == F_ADD || funct == F_SUB || funct == F_SLT))
               state_d = S_EXEC_R;
            else if (opcode == OP_RTYPE && funct == F_JR)
               state_d = S_JR;
            else if (opcode == OP_LW || opcode == OP_SW)
               state_d = S_MEM_ADDR;
            else if (opcode == OP_BEQ || opcode == OP_BNE)
               state_d = S_BRANCH;
            else if (opcode == OP_ADDI || opcode == OP_XORI)
               state_d = S_EXEC_I;
            else if (opcode == OP_J)
               state_d = S_JUMP;
            else if (opcode == OP_JAL)
               state_d = S_JAL;
            else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_EXEC_R: begin
            alusrc_a = 1'b1;
            if (funct == F_SUB)
               aluop = ALU_SUB;
            else if (funct == F_SLT)
               aluop = ALU_SLT;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_dest = 2'd1;
            reg_we   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXEC_I: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'd2;
            if (opcode == OP_XORI)
               aluop = ALU_XOR;
            state_d = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_we  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM_ADDR: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'd2;
            state_d  = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_done)
               state_d = S_MEM_WB;
            else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else
               wait_d = wait_q + 8'd1;
         end
         S_MEM_WB: begin
            mem_to_reg = 2'd1;
            reg_we     = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = 1'b1;
            if (mem_done) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (timed_out) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else
               wait_d = wait_q + 8'd1;
         end
         S_BRANCH: begin
            alusrc_a = 1'b1;
            aluop    = ALU_SUB;
            branch   = 1'b1;
            pc_src   = 2'd1;
            beq_sel  = (opcode == OP_BNE);
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = 2'd2;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            reg_dest   = 2'd2;
            mem_to_reg = 2'd3;
            reg_we     = 1'b1;
            pc_src     = 2'd2;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JR: begin
            pc_src  = 2'd3;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign retired_cnt = cnt_q;
   assign illegal     = illegal_q;
   assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: expected control vectors come from a per-state
// model of the control table and are queued, then compared against the DUT each cycle.
module tb_mcycle_ctrl;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       pc_we, iord, mem_req, mem_we, ir_write, reg_we, reg_src, alusrc_a, branch, beq_sel;
   logic [2:0] aluop;
   logic [1:0] reg_dest, mem_to_reg, alusrc_b, pc_src;
   logic       retire, halted, illegal, bus_err;
   logic [3:0] retired_cnt;

   typedef struct packed {
      logic       pc_we, iord, mem_req, mem_we, ir_write, reg_we, reg_src, alusrc_a, branch, beq_sel;
      logic [2:0] aluop;
      logic [1:0] reg_dest, mem_to_reg, alusrc_b, pc_src;
      logic       retire, halted, illegal, bus_err;
      logic [3:0] cnt;
   } obs_t;

   typedef enum {
      E_FETCH, E_DECODE, E_EXEC_R, E_ALU_WB, E_EXEC_I, E_IMM_WB, E_MEM_ADDR,
      E_MEM_RD, E_MEM_WB, E_MEM_WR, E_BRANCH, E_JUMP, E_JAL, E_JR, E_HALT
   } est_t;

   int         checks;
   int         errors;
   logic [3:0] exp_cnt;
   logic       exp_ill;
   logic       exp_berr;
   obs_t       sb_q[$];
   string      tag_q[$];
   obs_t       obs;

   mcycle_ctrl #(.MEM_HANDSHAKE(1), .TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .pc_we(pc_we), .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
      .reg_we(reg_we), .reg_src(reg_src), .alusrc_a(alusrc_a), .branch(branch),
      .beq_sel(beq_sel), .aluop(aluop), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
      .alusrc_b(alusrc_b), .pc_src(pc_src), .retire(retire), .retired_cnt(retired_cnt),
      .halted(halted), .illegal(illegal), .bus_err(bus_err)
   );

   assign obs = {pc_we, iord, mem_req, mem_we, ir_write, reg_we, reg_src, alusrc_a, branch,
                 beq_sel, aluop, reg_dest, mem_to_reg, alusrc_b, pc_src, retire, halted,
                 illegal, bus_err, retired_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t model(input est_t st, input logic rdy);
      obs_t e;
      e = '0;
      case (st)
         E_FETCH:    begin e.mem_req = 1; e.alusrc_b = 2'd1; e.ir_write = rdy; e.pc_we = rdy; end
         E_DECODE:   e.alusrc_b = 2'd3;
         E_EXEC_R:   begin
            e.alusrc_a = 1;
            e.aluop = (funct == 6'h22) ? 3'd1 : (funct == 6'h2A) ? 3'd3 : 3'd0;
         end
         E_ALU_WB:   begin e.reg_dest = 2'd1; e.reg_we = 1; e.retire = 1; end
         E_EXEC_I:   begin
            e.alusrc_a = 1; e.alusrc_b = 2'd2;
            e.aluop = (opcode == 6'h0E) ? 3'd2 : 3'd0;
         end
         E_IMM_WB:   begin e.reg_we = 1; e.retire = 1; end
         E_MEM_ADDR: begin e.alusrc_a = 1; e.alusrc_b = 2'd2; end
         E_MEM_RD:   begin e.mem_req = 1; e.iord = 1; end
         E_MEM_WB:   begin e.mem_to_reg = 2'd1; e.reg_we = 1; e.retire = 1; end
         E_MEM_WR:   begin e.mem_req = 1; e.iord = 1; e.mem_we = 1; e.retire = rdy; end
         E_BRANCH:   begin
            e.alusrc_a = 1; e.aluop = 3'd1; e.branch = 1; e.pc_src = 2'd1;
            e.beq_sel = (opcode == 6'h05); e.retire = 1;
         end
         E_JUMP:     begin e.pc_src = 2'd2; e.pc_we = 1; e.retire = 1; end
         E_JAL:      begin
            e.reg_dest = 2'd2; e.mem_to_reg = 2'd3; e.reg_we = 1;
            e.pc_src = 2'd2; e.pc_we = 1; e.retire = 1;
         end
         E_JR:       begin e.pc_src = 2'd3; e.pc_we = 1; e.retire = 1; end
         E_HALT:     e.halted = 1;
         default:    e = '0;
      endcase
      e.illegal = exp_ill;
      e.bus_err = exp_berr;
      e.cnt     = exp_cnt;
      return e;
   endfunction

   // Entered at a falling edge; leaves at the next falling edge.
   task automatic cyc(input est_t st, input logic rdy, input string tag);
      obs_t  e;
      obs_t  o;
      string t;
      if (!(st inside {E_FETCH, E_MEM_RD, E_MEM_WR}))
         rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      sb_q.push_back(model(st, rdy));
      tag_q.push_back(tag);
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      o = obs;
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", t, o, e);
      end
      if (e.retire)
         exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   task automatic fd(input logic [5:0] op, input logic [5:0] fn, input int waits, input string tag);
      opcode = op;
      funct  = fn;
      for (int i = 0; i < waits; i++)
         cyc(E_FETCH, 1'b0, {tag, "_fwait"});
      cyc(E_FETCH, 1'b1, {tag, "_fetch"});
      cyc(E_DECODE, 1'b1, {tag, "_decode"});
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      reset    = 1'b0;
      exp_cnt  = '0;
      exp_ill  = 1'b0;
      exp_berr = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      opcode    = '0;
      funct     = '0;
      exp_cnt   = '0;
      exp_ill   = 1'b0;
      exp_berr  = 1'b0;
      do_reset();

      fd(6'h00, 6'h20, 0, "add");  cyc(E_EXEC_R, 1, "add_exec");  cyc(E_ALU_WB, 1, "add_wb");
      fd(6'h00, 6'h22, 0, "sub");  cyc(E_EXEC_R, 1, "sub_exec");  cyc(E_ALU_WB, 1, "sub_wb");
      fd(6'h00, 6'h2A, 0, "slt");  cyc(E_EXEC_R, 1, "slt_exec");  cyc(E_ALU_WB, 1, "slt_wb");
      fd(6'h08, 6'h15, 0, "addi"); cyc(E_EXEC_I, 1, "addi_exec"); cyc(E_IMM_WB, 1, "addi_wb");
      fd(6'h0E, 6'h3C, 0, "xori"); cyc(E_EXEC_I, 1, "xori_exec"); cyc(E_IMM_WB, 1, "xori_wb");

      fd(6'h23, 6'h00, 0, "lw");
      cyc(E_MEM_ADDR, 1, "lw_addr");
      repeat (3) cyc(E_MEM_RD, 1'b0, "lw_rd_wait");
      cyc(E_MEM_RD, 1'b1, "lw_rd_done");
      cyc(E_MEM_WB, 1, "lw_wb");

      fd(6'h2B, 6'h00, 2, "sw");
      cyc(E_MEM_ADDR, 1, "sw_addr");
      repeat (2) cyc(E_MEM_WR, 1'b0, "sw_wr_wait");
      cyc(E_MEM_WR, 1'b1, "sw_wr_done");

      fd(6'h04, 6'h00, 0, "beq"); cyc(E_BRANCH, 1, "beq_br");
      fd(6'h05, 6'h00, 0, "bne"); cyc(E_BRANCH, 1, "bne_br");
      fd(6'h02, 6'h00, 0, "j");   cyc(E_JUMP, 1, "j_jump");
      fd(6'h03, 6'h00, 0, "jal"); cyc(E_JAL, 1, "jal_jal");
      fd(6'h00, 6'h08, 0, "jr");  cyc(E_JR, 1, "jr_jr");

      // 12 retired so far; four more wrap the 4-bit counter to 0
      repeat (4) begin
         fd(6'h02, 6'h00, 0, "wrap");
         cyc(E_JUMP, 1, "wrap_jump");
      end

      fd(6'h3F, 6'h00, 0, "ill_op");
      exp_ill = 1'b1;
      repeat (3) cyc(E_HALT, 1, "ill_op_halt");
      do_reset();

      fd(6'h00, 6'h21, 0, "ill_fn");
      exp_ill = 1'b1;
      repeat (2) cyc(E_HALT, 1, "ill_fn_halt");
      do_reset();

      opcode = 6'h00;
      funct  = 6'h20;
      repeat (15) cyc(E_FETCH, 1'b0, "fetch_tmo_wait");
      exp_berr = 1'b1;
      repeat (3) cyc(E_HALT, 1, "fetch_tmo_halt");
      do_reset();

      fd(6'h23, 6'h00, 0, "lw_tmo");
      cyc(E_MEM_ADDR, 1, "lw_tmo_addr");
      repeat (15) cyc(E_MEM_RD, 1'b0, "lw_tmo_wait");
      exp_berr = 1'b1;
      repeat (2) cyc(E_HALT, 1, "lw_tmo_halt");
      do_reset();

      fd(6'h00, 6'h20, 0, "pre_sw"); cyc(E_EXEC_R, 1, "pre_sw_exec"); cyc(E_ALU_WB, 1, "pre_sw_wb");
      fd(6'h2B, 6'h00, 0, "sw_rst");
      cyc(E_MEM_ADDR, 1, "sw_rst_addr");
      repeat (2) cyc(E_MEM_WR, 1'b0, "sw_rst_wait");
      do_reset();
      fd(6'h00, 6'h22, 0, "post_rst"); cyc(E_EXEC_R, 1, "post_rst_exec"); cyc(E_ALU_WB, 1, "post_rst_wb");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcycle_ctrl.md
MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = memory states last exactly one cycle and mem_ready is ignored.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles per memory access before a bus error; range 1..255.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-007 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-008 mem_ready  input  1  memory has completed the current request.
REQ-009 pc_we, iord, mem_req, mem_we, ir_write, reg_we, reg_src, alusrc_a, branch, beq_sel  output  1 each  datapath controls.
REQ-010 aluop  output  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT.
REQ-011 reg_dest, mem_to_reg, alusrc_b, pc_src  output  2 each  mux selects: reg_dest 0 rt/1 rd/2 r31; mem_to_reg 0 aluout/1 mdr/2 alu result/3 pc; alusrc_b 0 B/1 const 4/2 signimm/3 signimm<<2; pc_src 0 alu result/1 aluout/2 jump target/3 A.
REQ-012 retire  output  1  one-cycle pulse in the final state of each instruction.
REQ-013 retired_cnt  output  CNT_W  count of retired instructions.
REQ-014 halted, illegal, bus_err  output  1 each  sticky halt status with its cause.

Function
REQ-015 States: FETCH, DECODE, EXEC_R, ALU_WB, EXEC_I, IMM_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, HALT; every output not listed for a state SHALL be 0.
REQ-016 FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, aluop=ADD, pc_src=0; ir_write=pc_we=1 only in the completing cycle, which is the mem_ready=1 cycle (MEM_HANDSHAKE=1) or the single FETCH cycle (MEM_HANDSHAKE=0); completion moves to DECODE.
REQ-017 DECODE: alusrc_a=0, alusrc_b=3, aluop=ADD (branch target into aluout); next state by opcode/funct per REQ-018.
REQ-018 Decode map: 0x00 with funct 0x20/0x22/0x2A -> EXEC_R; 0x00 with funct 0x08 -> JR; 0x23 LW, 0x2B SW -> MEM_ADDR; 0x04 BEQ, 0x05 BNE -> BRANCH; 0x08 ADDI, 0x0E XORI -> EXEC_I; 0x02 -> JUMP; 0x03 -> JAL; all other encodings -> HALT with illegal=1.
REQ-019 EXEC_R: alusrc_a=1, alusrc_b=0; aluop ADD/SUB/SLT per funct. ALU_WB: reg_dest=1, mem_to_reg=0, reg_we=1, retire.
REQ-020 EXEC_I: alusrc_a=1, alusrc_b=2; aluop ADD for ADDI, XOR for XORI. IMM_WB: reg_dest=0, mem_to_reg=0, reg_we=1, retire.
REQ-021 MEM_ADDR: alusrc_a=1, alusrc_b=2, aluop=ADD; next MEM_RD for LW, MEM_WR for SW.
REQ-022 MEM_RD: mem_req=1, iord=1; on completion go to MEM_WB. MEM_WB: reg_dest=0, mem_to_reg=1, reg_we=1, retire.
REQ-023 MEM_WR: mem_req=1, iord=1; mem_we=1 every cycle in the state; retire on the completing cycle.
REQ-024 BRANCH: alusrc_a=1, alusrc_b=0, aluop=SUB, branch=1, pc_src=1, beq_sel=0 for BEQ and 1 for BNE, retire.
REQ-025 JUMP: pc_src=2, pc_we=1, retire. JAL: reg_dest=2, mem_to_reg=3, reg_we=1, pc_src=2, pc_we=1, retire. JR: reg_src=0 (rs), pc_src=3, pc_we=1, retire.
REQ-026 All states other than HALT and waiting memory states return to FETCH after one cycle.
REQ-027 Wait counter: cleared on entry to each memory state. It counts cycles with mem_ready=0. If it reaches TIMEOUT without completion, the next state is HALT with bus_err=1 and no ir_write, pc_we or reg_we is issued. Not used when MEM_HANDSHAKE=0.
REQ-028 HALT: halted=1; all controls 0. It is left only by reset; illegal and bus_err stay set until reset.
REQ-029 retired_cnt increments by 1 on each retire pulse and wraps from all-ones to 0.
REQ-030 Instruction latency with zero-wait memory: R/ADDI/XORI 4 cycles, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3.

Reset
REQ-031 When reset=1 at a clock edge: state becomes FETCH, the wait counter clears, and retired_cnt, halted, illegal and bus_err clear. Reset applies from any state, including mid-access.
REQ-032 Outputs are Moore-decoded from the state, except the completion-qualified signals in REQ-016/022/023, which depend on mem_ready.

Verification
REQ-033 Zero wait, ADD (opcode 0, funct 0x20): states FETCH, DECODE, EXEC_R, ALU_WB -> reg_we=1 with reg_dest=1 in cycle 4, retire=1, retired_cnt=1.
REQ-034 LW with mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles.
REQ-035 mem_ready held 0 in FETCH, TIMEOUT=15 -> HALT after 15 wait cycles with bus_err=1, halted=1, ir_write never asserted.
REQ-036 Opcode 0x3F -> HALT after DECODE with illegal=1, retired_cnt unchanged; reset -> FETCH with flags cleared.
REQ-037 BNE: BRANCH state shows beq_sel=1, branch=1, pc_src=1, aluop=1; JAL shows reg_dest=2, mem_to_reg=3, pc_src=2.
REQ-038 Reset asserted during MEM_WR wait -> next cycle state is FETCH, mem_we=0, retired_cnt=0; CNT_W=4 with 16 retires -> retired_cnt wraps to 0.
